// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for tick_timer and other consumers of the down-sampled tick.
package tick_timer_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// One-flop rising-edge detector for the down-sampled tick square wave.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_rise
);

    logic tick_q;

    // tick_q clears to 0, so a tick_in already high after reset counts as a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    assign tick_rise = tick_in & ~tick_q;

endmodule

// File: rtl/tick_timer.sv
// Interval timer counting tick rises: one-shot/periodic countdown plus a free-running elapsed count.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] duration,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] elapsed
);

    state_t           state;
    logic             tick_rise;
    logic             periodic_q;
    logic [CNT_W-1:0] duration_q;

    tick_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .tick_rise (tick_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            remaining  <= '0;
            elapsed    <= '0;
            duration_q <= '0;
            periodic_q <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick_rise) begin
                elapsed <= elapsed + CNT_W'(1);
            end
            // stop beats start, and start beats an expiring tick in the same cycle.
            if (stop) begin
                state     <= IDLE;
                remaining <= '0;
            end else if (start) begin
                if (duration != '0) begin
                    duration_q <= duration;
                    periodic_q <= periodic;
                    remaining  <= duration;
                    state      <= RUN;
                end else begin
                    state     <= IDLE;
                    remaining <= '0;
                    done      <= 1'b1;
                end
            end else if (state == RUN && tick_rise) begin
                if (remaining > CNT_W'(1)) begin
                    remaining <= remaining - CNT_W'(1);
                end else if (periodic_q) begin
                    remaining <= duration_q;
                    done      <= 1'b1;
                end else begin
                    remaining <= '0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer (32-bit instance plus an 8-bit instance for wrap).
module tb_tick_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_in = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        periodic = 1'b0;
    logic [31:0] duration = '0;

    logic        busy, done;
    logic [31:0] remaining, elapsed;
    logic        busy8, done8;
    logic [7:0]  remaining8, elapsed8;

    int passed = 0;
    int total = 0;
    int done_cnt = 0;
    int done_mark;
    logic [31:0] exp_elapsed = '0;

    tick_timer dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .duration  (duration),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .elapsed   (elapsed)
    );

    tick_timer #(.CNT_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .duration  (duration[7:0]),
        .busy      (busy8),
        .done      (done8),
        .remaining (remaining8),
        .elapsed   (elapsed8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick rise: the countdown updates at the first edge, tick_in low again after the second.
    task automatic rise_hi();
        tick_in = 1'b1;
        step();
        exp_elapsed++;
    endtask

    task automatic rise_lo();
        tick_in = 1'b0;
        step();
    endtask

    task automatic rise();
        rise_hi();
        rise_lo();
    endtask

    task automatic do_start(input logic [31:0] dur, input logic per);
        start = 1'b1;
        duration = dur;
        periodic = per;
        step();
        start = 1'b0;
        duration = 32'hDEAD_BEEF;
        periodic = ~per;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_elapsed", elapsed, 0);
        rst = 1'b1;
        step();

        // Elapsed counting while idle
        for (int i = 0; i < 5; i++) rise();
        chk("elapsed5", elapsed, 5);
        chk("idle_busy", busy, 0);
        chk("idle_no_done", done_cnt, 0);

        // One-shot, duration 3
        do_start(3, 1'b0);
        chk("os_busy", busy, 1);
        chk("os_rem3", remaining, 3);
        rise();
        chk("os_rem2", remaining, 2);
        rise();
        chk("os_rem1", remaining, 1);
        chk("os_no_done_yet", done_cnt, 0);
        rise_hi();
        chk("os_rem0", remaining, 0);
        chk("os_done", done, 1);
        chk("os_busy_drop", busy, 0);
        rise_lo();
        chk("os_done_1cycle", done, 0);
        chk("os_done_count", done_cnt, 1);
        chk("os_elapsed", elapsed, exp_elapsed);

        // Periodic, duration 2, six rises
        do_start(2, 1'b1);
        chk("per_rem", remaining, 2);
        for (int i = 1; i <= 6; i++) begin
            rise_hi();
            chk("per_done", done, (i % 2 == 0) ? 1 : 0);
            chk("per_rem_i", remaining, (i % 2 == 0) ? 2 : 1);
            chk("per_busy", busy, 1);
            rise_lo();
        end
        chk("per_done_count", done_cnt, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("per_stop_busy", busy, 0);

        // Stop after 4 of 10 rises
        do_start(10, 1'b0);
        for (int i = 0; i < 4; i++) rise();
        chk("stop_rem6", remaining, 6);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_rem", remaining, 0);
        step();
        chk("stop_no_done", done_cnt, 4);

        // start and stop together, from IDLE and from RUN
        start = 1'b1; stop = 1'b1; duration = 5;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_idle_busy", busy, 0);
        chk("ss_idle_rem", remaining, 0);
        do_start(5, 1'b0);
        start = 1'b1; stop = 1'b1; duration = 9; tick_in = 1'b1;
        step();
        exp_elapsed++;
        start = 1'b0; stop = 1'b0; tick_in = 1'b0;
        step();
        chk("ss_run_busy", busy, 0);
        chk("ss_run_rem", remaining, 0);
        chk("ss_no_done", done_cnt, 4);

        // Restart with a coinciding tick rise
        do_start(5, 1'b0);
        rise();
        chk("rs_rem4", remaining, 4);
        start = 1'b1; duration = 2; periodic = 1'b0; tick_in = 1'b1;
        step();
        exp_elapsed++;
        start = 1'b0; tick_in = 1'b0;
        chk("rs_rem2", remaining, 2);
        chk("rs_busy", busy, 1);
        chk("rs_no_done", done, 0);
        chk("rs_elapsed", elapsed, exp_elapsed);
        step();
        rise();
        chk("rs_rem1", remaining, 1);
        rise_hi();
        chk("rs_done", done, 1);
        chk("rs_busy_drop", busy, 0);
        rise_lo();
        chk("rs_done_count", done_cnt, 5);

        // Restart in RUN with duration 0
        do_start(4, 1'b1);
        do_start(0, 1'b0);
        chk("rz_done", done, 1);
        chk("rz_busy", busy, 0);
        chk("rz_rem", remaining, 0);
        step();

        // Start with duration 0 from IDLE
        do_start(0, 1'b0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_rem", remaining, 0);
        step();
        chk("z_done_1cycle", done, 0);
        chk("z_done_count", done_cnt, 7);

        // Asynchronous reset during RUN
        do_start(7, 1'b0);
        chk("ar_rem7", remaining, 7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_rem", remaining, 0);
        chk("ar_elapsed", elapsed, 0);
        exp_elapsed = 0;
        step();
        rst = 1'b1;
        done_mark = done_cnt;
        for (int i = 0; i < 8; i++) rise();
        chk("ar_no_done", done_cnt, done_mark);
        chk("ar_busy_after", busy, 0);

        // Elapsed wrap on the 8-bit instance
        for (int i = 0; i < 247; i++) rise();
        chk("wrap_pre", elapsed8, 255);
        rise();
        chk("wrap_zero", elapsed8, 0);
        chk("wrap_elapsed32", elapsed, 256);
        chk("wrap_model", elapsed, exp_elapsed);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tick_timer.md
# tick_timer

Millisecond/microsecond interval timer that consumes the toggling slow-clock signal produced by the team's clock down-sampler. It counts rising edges of that signal as time units. It provides a programmable one-shot or periodic countdown with a start/stop/done handshake, plus a free-running elapsed-unit counter. It sits between the down-sampler and the control FSMs that need timeouts and delays.

## Interface
- CNT_W, 32, width of duration, remaining and elapsed counters
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_in  in  1  down-sampled square wave, already in clk domain; one rising edge = one time unit
- start  in  1  single-cycle request: load duration and begin counting
- stop  in  1  single-cycle abort of a running countdown
- periodic  in  1  sampled with start; 1 = auto-reload, 0 = one-shot
- duration  in  CNT_W  countdown length in units, sampled with start
- busy  out  1  countdown in progress
- done  out  1  one-cycle pulse on countdown expiry
- remaining  out  CNT_W  units left in current countdown
- elapsed  out  CNT_W  free-running rising-edge count since reset

## Operation
- Edge detect: tick_q <= tick_in; tick_rise = tick_in & ~tick_q. tick_q resets to 0, so tick_in high on the first cycle after reset counts as a rise.
- elapsed increments on every tick_rise regardless of state. It wraps from 2^CNT_W-1 to 0 with no flag.
- States: IDLE, RUN. busy = (state == RUN).
- IDLE, start=1, duration>0: latch duration_q <= duration and periodic_q <= periodic. Load remaining <= duration and go to RUN. A tick_rise in the same cycle is ignored by the countdown.
- IDLE, start=1, duration==0: done pulses the next cycle. Stay in IDLE. remaining stays 0.
- RUN, tick_rise, remaining>1: remaining decrements by 1.
- RUN, tick_rise, remaining==1, one-shot: remaining <= 0, done <= 1, go to IDLE.
- RUN, tick_rise, remaining==1, periodic: remaining <= duration_q, done <= 1, stay in RUN.
- RUN, start=1 (no stop): restart. Re-latch duration, periodic and remaining. The concurrent tick_rise is ignored and no done is issued. A restart with duration==0 goes to IDLE with a done pulse.
- stop=1 in any state: go to IDLE, remaining <= 0, no done. stop has priority over start and over an expiring tick in the same cycle.
- The duration and periodic inputs are ignored except in a start cycle.

## Timing
- Reset values: busy=0, done=0, remaining=0, elapsed=0, state=IDLE, tick_q=0, duration_q=0, periodic_q=0.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Start accepted at clock edge k: busy=1 and remaining=duration from edge k onward.
- tick_rise is visible in the cycle before edge k: remaining and elapsed update at edge k.
- On expiry, done is high for exactly one cycle, k to k+1, and busy drops at the same edge k for one-shot.
- Countdown length: exactly N tick rises after the start edge for duration=N.
- Periodic mode: done pulses every N rises, with no slip at reload.
- Reset mid-countdown: all state clears immediately and asynchronously. No done is emitted.

## Structure
- Shared package tick_timer_pkg holds:
  - state enum {IDLE, RUN}
  - CNT_W default localparam
- Sub-module tick_edge_detect: the one-flop rise detector on tick_in, reusable by other tick consumers.
- The countdown FSM and elapsed counter live in tick_timer.

## Test plan
- Reset and elapsed:
  - Reset, then 5 tick_in rising edges -> elapsed=5, busy=0, done never asserted.
  - Force elapsed to 2^CNT_W-1 (CNT_W=8 build) plus one rise -> elapsed=0.
- One-shot: start with duration=3, periodic=0 -> busy=1 next cycle; remaining goes 3,2,1,0 on successive rises. done pulses once on the 3rd rise; busy=0 the same edge.
- Periodic: start with duration=2, periodic=1, then 6 rises -> done pulses on rises 2, 4 and 6; busy stays 1; remaining reloads to 2 each time.
- Stop and restart:
  - Start with duration=10, 4 rises, then stop -> busy=0, remaining=0, no done.
  - start and stop in the same cycle -> IDLE.
  - Restart mid-run with duration=2 while a tick_rise coincides -> remaining=2, and the tick is not counted.
- Edge cases:
  - start with duration=0 -> done pulse next cycle, busy stays 0.
  - Assert rst low during RUN with remaining=7 -> all outputs 0 immediately; after release, no done is emitted.
